// File: rtl/net_loopback_model.sv
// Store-and-forward loopback endpoint: whole egress packets are buffered, then
// replayed on ingress through a token-bucket rate limiter.
module net_loopback_model #(
  parameter int          DATA_W        = 64,
  parameter int          DEPTH         = 32,
  parameter logic [47:0] MAC_ADDR      = 48'h00_12_6D_00_00_02,
  parameter int          RLIMIT_INC    = 1,
  parameter int          RLIMIT_PERIOD = 0,
  parameter int          RLIMIT_SIZE   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                net_out_valid,
  output logic                net_out_ready,
  input  logic [DATA_W-1:0]   net_out_bits_data,
  input  logic [DATA_W/8-1:0] net_out_bits_keep,
  input  logic                net_out_bits_last,
  output logic                net_in_valid,
  input  logic                net_in_ready,
  output logic [DATA_W-1:0]   net_in_bits_data,
  output logic [DATA_W/8-1:0] net_in_bits_keep,
  output logic                net_in_bits_last,
  output logic [47:0]         net_macAddr,
  output logic [7:0]          net_rlimit_inc,
  output logic [7:0]          net_rlimit_period,
  output logic [7:0]          net_rlimit_size,
  output logic [15:0]         drop_count,
  output logic [15:0]         pkt_count
);

  localparam int KEEP_W  = DATA_W / 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRY_W = DATA_W + KEEP_W + 1;

  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [9:0]    INC_W    = 10'(RLIMIT_INC);
  localparam logic [9:0]    SIZE_W   = 10'(RLIMIT_SIZE);
  localparam logic [7:0]    PERIOD_B = 8'(RLIMIT_PERIOD);

  typedef enum logic {
    ST_RECV = 1'b0,
    ST_DROP = 1'b1
  } state_t;

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] cp_q, cp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [7:0]    tokens_q, tokens_d;
  logic [7:0]    refill_cnt_q, refill_cnt_d;
  logic [15:0]   drop_q, drop_d;
  logic [15:0]   pkt_q, pkt_d;

  logic               accept;
  logic               full;
  logic               wr_en;
  logic               xfer;
  logic               refill;
  logic [15:0]        drop_inc;
  logic [9:0]         tok_sum;
  logic [ENTRY_W-1:0] rd_entry;

  assign net_out_ready = ~reset;
  assign accept        = net_out_valid & net_out_ready;
  // Occupancy counts uncommitted flits too, so an oversized packet overflows.
  assign full          = (wp_q - rp_q) == DEPTH_P;
  assign drop_inc      = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  // Egress: write while space remains, roll back to the last committed packet on overflow.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    cp_d    = cp_q;
    drop_d  = drop_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_RECV: begin
        if (accept) begin
          if (!full) begin
            wr_en = 1'b1;
            wp_d  = wp_q + PW'(1);
            if (net_out_bits_last) cp_d = wp_q + PW'(1);
          end else begin
            wp_d = cp_q;
            if (net_out_bits_last) drop_d = drop_inc;
            else                   state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (accept && net_out_bits_last) begin
          drop_d  = drop_inc;
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wp_q[AW-1:0]] <= {net_out_bits_data, net_out_bits_keep, net_out_bits_last};
  end

  assign rd_entry         = mem_q[rp_q[AW-1:0]];
  assign net_in_bits_data = rd_entry[ENTRY_W-1 -: DATA_W];
  assign net_in_bits_keep = rd_entry[KEEP_W:1];
  assign net_in_bits_last = rd_entry[0];
  assign net_in_valid     = ~reset & (cp_q != rp_q) & (tokens_q != 8'd0);
  assign xfer             = net_in_valid & net_in_ready;

  // Ingress pointer, packet counter and token bucket; 10-bit sum cannot wrap.
  always_comb begin
    rp_d         = rp_q + (xfer ? PW'(1) : PW'(0));
    pkt_d        = pkt_q + ((xfer && net_in_bits_last) ? 16'd1 : 16'd0);
    refill       = (refill_cnt_q == PERIOD_B);
    refill_cnt_d = refill ? 8'd0 : refill_cnt_q + 8'd1;
    tok_sum      = {2'b00, tokens_q} + (refill ? INC_W : 10'd0) - (xfer ? 10'd1 : 10'd0);
    tokens_d     = (tok_sum > SIZE_W) ? SIZE_W[7:0] : tok_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RECV;
      wp_q         <= '0;
      cp_q         <= '0;
      rp_q         <= '0;
      tokens_q     <= SIZE_W[7:0];
      refill_cnt_q <= '0;
      drop_q       <= '0;
      pkt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      cp_q         <= cp_d;
      rp_q         <= rp_d;
      tokens_q     <= tokens_d;
      refill_cnt_q <= refill_cnt_d;
      drop_q       <= drop_d;
      pkt_q        <= pkt_d;
    end
  end

  assign net_macAddr       = MAC_ADDR;
  assign net_rlimit_inc    = 8'(RLIMIT_INC);
  assign net_rlimit_period = PERIOD_B;
  assign net_rlimit_size   = SIZE_W[7:0];
  assign drop_count        = drop_q;
  assign pkt_count         = pkt_q;

endmodule

// File: doc/net_loopback_model.md
Name: net_loopback_model

Overview:
- Parametrised, synthesizable network endpoint model for NIC simulation and FPGA bring-up.
- Accepts NIC egress flits, buffers whole packets store-and-forward, and returns them on NIC ingress (loopback).
- Ingress is shaped by a token-bucket rate limiter and supports ready/valid backpressure in both directions.
- Drives the NIC's static config outputs (MAC address, rate-limit settings) from parameters, and reports drop and forward counters.

Parameters:
DATA_W, 64, flit data width in bits; multiple of 8.
DEPTH, 32, FIFO depth in flits; power of 2, >= 4.
MAC_ADDR, 48'h00_12_6D_00_00_02, value driven on net_macAddr.
RLIMIT_INC, 1, tokens added per refill.
RLIMIT_PERIOD, 0, refill occurs every RLIMIT_PERIOD+1 cycles.
RLIMIT_SIZE, 8, token bucket capacity; 1..255.

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
net_out_valid  in  1  egress flit valid
net_out_ready  out  1  egress ready
net_out_bits_data  in  DATA_W  egress data
net_out_bits_keep  in  DATA_W/8  egress byte mask
net_out_bits_last  in  1  egress last flit of packet
net_in_valid  out  1  ingress flit valid
net_in_ready  in  1  ingress ready
net_in_bits_data  out  DATA_W  ingress data
net_in_bits_keep  out  DATA_W/8  ingress byte mask
net_in_bits_last  out  1  ingress last flit
net_macAddr  out  48  equals MAC_ADDR
net_rlimit_inc  out  8  equals RLIMIT_INC
net_rlimit_period  out  8  equals RLIMIT_PERIOD
net_rlimit_size  out  8  equals RLIMIT_SIZE
drop_count  out  16  packets dropped; saturates at 16'hFFFF
pkt_count  out  16  packets forwarded on ingress; wraps

Behaviour:
- Reset (synchronous, active-high): all FIFO pointers are 0; state is IDLE; tokens = RLIMIT_SIZE; refill counter = 0; both counters = 0.
- During reset: net_out_ready = 0 and net_in_valid = 0.
- Outside reset: net_out_ready = 1 always, so the egress side never stalls.
- Storage: DEPTH-entry RAM of {data, keep, last}. It has a write pointer wp, a committed pointer cp, and a read pointer rp, each log2(DEPTH)+1 bits.
- Full means wp - rp == DEPTH. Committed-empty means cp == rp.
- The egress state machine has two states, IDLE/RECV and DROP.
- IDLE/RECV, accepted flit, not full: write it at wp and increment wp.
  - If last is also set, set cp to the new wp and stay in IDLE.
- IDLE/RECV, accepted flit, FIFO full: roll wp back to cp.
  - If last is set, increment drop_count and stay in IDLE.
  - Otherwise go to DROP.
- DROP: discard flits. On an accepted last, increment drop_count and return to IDLE.
- Consequence: any packet longer than DEPTH flits is always dropped.
- Full check timing: the full check uses the wp before the write in that cycle. A read in the same cycle does not free space until the next cycle.
- Ingress: net_in_valid = !committed-empty && tokens != 0. Data, keep and last are read from RAM[rp] (first-word fall-through from registered storage).
- Ingress transfer (valid && ready): increment rp and consume 1 token. If last, increment pkt_count.
- Latency: a packet whose last flit is accepted in cycle t shows its first flit on net_in_valid in cycle t+1 at the earliest.
- Rate limiter: the refill counter counts 0..RLIMIT_PERIOD. On the cycle it equals RLIMIT_PERIOD it wraps to 0 and a refill occurs.
  - Next tokens = min(RLIMIT_SIZE, tokens + (refill ? RLIMIT_INC : 0) - (transfer ? 1 : 0)).
  - Compute this at 10-bit width, so there is no underflow or wrap.
- Simultaneous commit and read in the same cycle are both applied. The read sees the pre-commit cp.
- keep is passed through unmodified, including all-zero values. The block does no keep checking.
- Reset mid-packet discards all buffered and partial data.
- If net_in_ready is held low, flits stay stable on the ingress port. Egress continues and drops once the FIFO is full.

Test Plan:
- DATA_W=64, RLIMIT_SIZE=8, PERIOD=0. Send one 3-flit packet (data 1,2,3; keep FF,FF,0F). -> Ingress shows the same 3 flits starting the cycle after the last flit; pkt_count=1; drop_count=0.
- DEPTH=8, in_ready=0. Send a 5-flit packet, then a 4-flit packet. -> Second packet dropped; drop_count=1. With in_ready=1, only the 5 flits of the first packet appear.
- DEPTH=8. Send one 10-flit packet with in_ready=1. -> Dropped, drop_count=1, no ingress output. A following 2-flit packet loops back correctly.
- RLIMIT_INC=1, PERIOD=3, SIZE=2, in_ready=1. Commit one 8-flit packet. -> First 2 flits on consecutive cycles, then 1 flit per 4 cycles; tokens never exceed 2.
- Toggle in_ready pseudo-randomly on a 4-flit packet. -> Each flit is held stable while valid && !ready; order and last are preserved.
- Assert reset after flit 2 of a 4-flit packet, then deassert and send a fresh 1-flit packet. -> Only the new flit appears; counters are 0 then pkt_count=1.
